// File: rtl/instrument_tx.sv
// instrument_tx: serialises bass/drum/guitar note state onto an 8N1 UART line.
// Each frame byte is {data[4:0], id[2:0]}; ids bass=001, drum=010, guitar=100.
// A frame is queued whenever an instrument's input differs from the value it
// last sent, on send_all, or on the periodic refresh tick. Pending instruments
// are served round-robin, starting after the one most recently sent.
//
// Ports:
//   clk        - single clock, posedge
//   rst        - synchronous, active-high reset
//   bass       - 5-bit bass note state
//   drum       - 5-bit drum note/foot state
//   guitar     - 5-bit guitar note state
//   send_all   - one-cycle pulse queueing all three instruments
//   TxD        - registered serial output, idle high
//   busy       - high during start, data and stop bits
//   frame_sent - one-cycle pulse when a stop bit completes
//
// state | meaning
// IDLE  | line high, waiting for a pending instrument
// START | start bit (0) for BIT_CYC cycles
// DATA  | eight data bits, LSB (id) first, BIT_CYC cycles each
// STOP  | stop bit (1) for BIT_CYC cycles
module instrument_tx #(
  parameter int CLK_HZ      = 27000000,
  parameter int BAUD        = 115200,
  parameter int REFRESH_CYC = 2700000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] bass,
  input  logic [4:0] drum,
  input  logic [4:0] guitar,
  input  logic       send_all,
  output logic       TxD,
  output logic       busy,
  output logic       frame_sent
);

  localparam int          BIT_CYC      = CLK_HZ / BAUD;
  localparam logic [31:0] BIT_LAST     = 32'(BIT_CYC - 1);
  localparam logic [31:0] REFRESH_LAST = (REFRESH_CYC > 0) ? 32'(REFRESH_CYC - 1) : 32'd0;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [7:0]      shreg;
  logic [2:0]      bit_idx;
  logic [31:0]     bit_cnt;
  logic [31:0]     refresh_cnt;
  logic [2:0][4:0] inst_in;
  logic [2:0][4:0] last_sent;
  logic [2:0]      pending;
  logic [2:0]      set_req;
  logic [2:0]      capture;
  logic [1:0]      rr_ptr;
  logic [1:0]      sel;
  logic            refresh_hit;
  logic            start_frame;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  assign inst_in = {guitar, drum, bass};

  always_comb begin
    refresh_hit = (REFRESH_CYC > 0) && (refresh_cnt == REFRESH_LAST);
    sel = rr_ptr;
    if (!pending[rr_ptr]) begin
      if (pending[next_idx(rr_ptr)]) sel = next_idx(rr_ptr);
      else                           sel = next_idx(next_idx(rr_ptr));
    end
    start_frame = (state == IDLE) && (pending != 3'b000);
    capture = start_frame ? (3'b001 << sel) : 3'b000;
    // The instrument being captured is compared against the value it is about
    // to record, so only send_all/refresh can re-arm it on the capture cycle.
    for (int i = 0; i < 3; i++)
      set_req[i] = send_all | refresh_hit | (!capture[i] && (inst_in[i] != last_sent[i]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      TxD         <= 1'b1;
      busy        <= 1'b0;
      frame_sent  <= 1'b0;
      pending     <= 3'b000;
      last_sent   <= '0;
      refresh_cnt <= '0;
      rr_ptr      <= 2'd0;
      shreg       <= 8'h00;
      bit_idx     <= 3'd0;
      bit_cnt     <= '0;
    end else begin
      frame_sent <= 1'b0;
      pending    <= (pending & ~capture) | set_req;
      if (REFRESH_CYC > 0)
        refresh_cnt <= refresh_hit ? 32'd0 : refresh_cnt + 32'd1;

      case (state)
        IDLE: begin
          TxD  <= 1'b1;
          busy <= 1'b0;
          if (start_frame) begin
            shreg          <= {inst_in[sel], 3'b001 << sel};
            last_sent[sel] <= inst_in[sel];
            rr_ptr         <= next_idx(sel);
            bit_cnt        <= BIT_LAST;
            TxD            <= 1'b0;
            busy           <= 1'b1;
            state          <= START;
          end
        end
        START: begin
          if (bit_cnt == '0) begin
            bit_cnt <= BIT_LAST;
            bit_idx <= 3'd0;
            TxD     <= shreg[0];
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt - 32'd1;
          end
        end
        DATA: begin
          if (bit_cnt == '0) begin
            bit_cnt <= BIT_LAST;
            if (bit_idx == 3'd7) begin
              TxD   <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= shreg >> 1;
              TxD     <= shreg[1];
            end
          end else begin
            bit_cnt <= bit_cnt - 32'd1;
          end
        end
        STOP: begin
          if (bit_cnt == '0) begin
            busy       <= 1'b0;
            frame_sent <= 1'b1;
            state      <= IDLE;
          end else begin
            bit_cnt <= bit_cnt - 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instrument_tx.sv
// Scoreboard bench for instrument_tx at BIT_CYC=16. Stimulus pushes expected
// frame bytes; an independent monitor deserialises TxD and pops/compares.
module tb_instrument_tx;

  typedef struct {
    logic [7:0] data;
    bit         b2b;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst2 = 1'b1;
  logic [4:0] bass = '0, drum = '0, guitar = '0;
  logic       send_all = 1'b0;
  logic [4:0] zero5 = '0;
  logic       zero1 = 1'b0;
  logic       txd1, busy1, fs1, txd2, busy2, fs2;
  logic       use_ref = 1'b0;
  logic       mon_txd, mon_busy, mon_fs, mon_rst;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_active = 0;
  int   prev_start = -1000;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instrument_tx #(.CLK_HZ(1600), .BAUD(100), .REFRESH_CYC(0)) dut (
    .clk(clk), .rst(rst), .bass(bass), .drum(drum), .guitar(guitar),
    .send_all(send_all), .TxD(txd1), .busy(busy1), .frame_sent(fs1));

  instrument_tx #(.CLK_HZ(1600), .BAUD(100), .REFRESH_CYC(200)) dut_ref (
    .clk(clk), .rst(rst2), .bass(zero5), .drum(zero5), .guitar(zero5),
    .send_all(zero1), .TxD(txd2), .busy(busy2), .frame_sent(fs2));

  assign mon_txd  = use_ref ? txd2  : txd1;
  assign mon_busy = use_ref ? busy2 : busy1;
  assign mon_fs   = use_ref ? fs2   : fs1;
  assign mon_rst  = use_ref ? rst2  : rst;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input bit b2b);
    exp_t e;
    e.data = d;
    e.b2b  = b2b;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name, input int max);
    int k = 0;
    while ((exp_q.size() != 0 || mon_active) && k < max) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (k >= max) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout with %0d frames outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_busy(input string name, input int max);
    int k = 0;
    while (!mon_busy && k < max) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= max) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: busy never rose, got 0 required 1", name);
    end
  endtask

  // Monitor: deserialise one frame per falling TxD, checking every cycle of it.
  initial begin
    logic [9:0] bits;
    bit         shape_bad, busy_bad, fs_bad, aborted;
    int         start_cyc;
    logic [7:0] got;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (!mon_rst && mon_txd == 1'b0) begin
        mon_active = 1;
        start_cyc  = cyc;
        bits       = '0;
        shape_bad  = 0;
        busy_bad   = 0;
        fs_bad     = 0;
        aborted    = 0;
        for (int c = 0; c < 160; c++) begin
          if (c > 0) @(negedge clk);
          if (mon_rst) begin
            aborted = 1;
            break;
          end
          if (c % 16 == 0) bits[c / 16] = mon_txd;
          else if (mon_txd != bits[c / 16]) shape_bad = 1;
          if (!mon_busy) busy_bad = 1;
          if (mon_fs) fs_bad = 1;
        end
        if (!aborted) begin
          @(negedge clk);
          if (mon_rst) aborted = 1;
        end
        if (!aborted) begin
          check("frame_end_fs_txd_busy", {mon_fs, mon_txd, mon_busy}, 3'b110);
          check("framing_shape_start_stop", {shape_bad, bits[0], bits[9]}, 3'b001);
          check("busy_in_frame", busy_bad, 0);
          check("no_early_frame_sent", fs_bad, 0);
          got = bits[8:1];
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_frame: got %02h, required no frame", got);
          end else begin
            e = exp_q.pop_front();
            check("frame_data", got, e.data);
            if (e.b2b) check("frame_gap", start_cyc - prev_start, 161);
          end
          prev_start = start_cyc;
        end
        mon_active = 0;
      end
    end
  end

  initial begin
    // Reset state
    tick(3);
    check("rst_txd", txd1, 1);
    check("rst_busy", busy1, 0);
    check("rst_frame_sent", fs1, 0);
    check("rst_txd_ref", txd2, 1);
    rst = 1'b0;
    tick(3);
    check("idle_no_spurious_busy", busy1, 0);

    // Single bass frame
    push(8'h19, 0);
    bass = 5'b00011;
    drain("single_bass", 600);

    // Simultaneous change of all three
    bass = '0; drum = '0; guitar = '0; rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    push(8'h19, 0); push(8'h82, 1); push(8'hFC, 1);
    bass = 5'b00011; drum = 5'b10000; guitar = 5'b11111;
    drain("three_changes", 1200);

    // Change during guitar frame in flight
    push(8'h0C, 0);
    guitar = 5'b00001;
    wait_busy("guitar_busy", 50);
    tick(40);
    push(8'h14, 1);
    guitar = 5'b00010;
    drain("guitar_midframe", 800);

    // send_all with all inputs zero
    bass = '0; drum = '0; guitar = '0; rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    push(8'h01, 0); push(8'h02, 1); push(8'h04, 1);
    send_all = 1'b1;
    tick(1);
    send_all = 1'b0;
    drain("send_all", 1200);

    // A->B->A on bass while drum is in flight: no cancellation
    push(8'h2A, 0);
    drum = 5'b00101;
    wait_busy("drum_busy", 50);
    tick(20);
    bass = 5'b00111;
    tick(20);
    bass = 5'b00000;
    push(8'h01, 1);
    drain("aba_resend", 800);

    // Reset during DATA bit 3, then fresh frames after release
    bass = 5'b00011;
    wait_busy("abort_busy", 50);
    tick(70);
    rst = 1'b1;
    tick(1);
    check("abort_txd", txd1, 1);
    check("abort_busy", busy1, 0);
    check("abort_no_frame_sent", fs1, 0);
    tick(1);
    check("abort_hold_frame_sent", fs1, 0);
    push(8'h19, 0); push(8'h2A, 1);
    rst = 1'b0;
    drain("after_abort", 900);

    // Periodic refresh instance
    use_ref = 1'b1;
    tick(2);
    rst2 = 1'b0;
    push(8'h01, 0); push(8'h02, 1); push(8'h04, 1);
    push(8'h01, 1); push(8'h02, 1); push(8'h04, 1);
    drain("refresh", 3000);
    rst2 = 1'b1;
    tick(3);
    check("refresh_reset_txd", txd2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instrument_tx.md
INSTRUMENT_TX -- requirements
Module: instrument_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 27000000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning the serial bit rate; BIT_CYC = CLK_HZ/BAUD, truncated integer division.
REQ-003 SHALL have parameter REFRESH_CYC, default 2700000, meaning clk cycles between forced resends of all three instruments; 0 disables refresh.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on posedge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port bass, input, 5 bits: current bass note state.
REQ-007 SHALL have port drum, input, 5 bits: current drum note/foot state.
REQ-008 SHALL have port guitar, input, 5 bits: current guitar note state.
REQ-009 SHALL have port send_all, input, 1 bit: a one-cycle pulse that queues all three instruments.
REQ-010 SHALL have port TxD, output, 1 bit: the serial line, 8N1, idle high.
REQ-011 SHALL have port busy, output, 1 bit: high from start-bit entry through the end of the stop bit.
REQ-012 SHALL have port frame_sent, output, 1 bit: a one-cycle pulse on the cycle the stop bit completes.

Function
REQ-013 SHALL encode each frame byte as [2:0]=ID and [7:3]=data; IDs: bass 3'b001, drum 3'b010, guitar 3'b100.
REQ-014 SHALL keep a 5-bit last_sent register and a pending flag per instrument.
REQ-015 SHALL set pending[i] on any cycle where input i differs from last_sent[i], where send_all=1, or where the refresh counter reaches REFRESH_CYC-1.
REQ-016 SHALL reset the refresh counter to 0 on reaching REFRESH_CYC-1 and otherwise increment it every cycle.
REQ-017 SHALL choose among pending instruments round-robin in order bass->drum->guitar->bass, starting after the last one sent; after reset, bass has first priority.
REQ-018 SHALL use FSM states IDLE, START, DATA, STOP; IDLE->START on the first cycle any pending bit is set and no transmission is active.
REQ-019 SHALL, on the IDLE->START transition, capture the selected input value into the shift register and last_sent, and clear that pending bit in the same cycle; a set request arriving in that same cycle for the same instrument takes priority.
REQ-020 SHALL hold each bit for exactly BIT_CYC cycles: START drives 0, DATA drives bits 0..7 LSB first (so the ID goes out first), STOP drives 1.
REQ-021 SHALL return STOP->IDLE after BIT_CYC cycles, pulse frame_sent, and allow the next frame's start bit in the following cycle (one idle-high cycle minimum between frames).
REQ-022 SHALL keep input changes during a frame from altering the frame in flight; they set pending only, and the latest value is sent later.
REQ-023 SHALL drive TxD from a register (glitch-free); busy=1 in START, DATA and STOP.
REQ-024 SHALL send a value once per change; if an input changes A->B->A before it is selected and A equals last_sent, pending stays set and A is resent (no cancellation).

Reset
REQ-025 SHALL, while rst=1, force next edge: TxD=1, busy=0, frame_sent=0, FSM=IDLE, pending=0, last_sent=0 for all, refresh counter=0, round-robin pointer=bass.
REQ-026 SHALL abort any frame in progress when rst asserts mid-frame; TxD returns high at the next edge with no partial stop bit.
REQ-027 SHALL, after reset release, send any nonzero inputs via the change rule.

Verification (CLK_HZ=1600, BAUD=100 -> BIT_CYC=16, REFRESH_CYC=0)
REQ-028 SHALL pass a test where, after reset, bass=5'b00011 -> one frame 0x19: TxD low for 16 cycles, then bits 1,0,0,1,1,0,0,0, then high for 16 cycles; frame_sent pulses once.
REQ-029 SHALL pass a test where bass=00011, drum=10000 and guitar=11111 change on the same cycle -> frames 0x19, 0x82, 0xFC in that order, back-to-back with one idle cycle between each.
REQ-030 SHALL pass a test where guitar changes 00001->00010 mid-frame of the guitar frame 0x0C -> the frame completes as 0x0C, followed by 0x14.
REQ-031 SHALL pass a test where send_all pulses with inputs unchanged (bass=0, drum=0, guitar=0) -> frames 0x01, 0x02, 0x04.
REQ-032 SHALL pass a test where rst asserts during DATA bit 3 -> TxD=1 and busy=0 on the next edge, with no frame_sent pulse; inputs still nonzero after release cause a fresh full frame.
REQ-033 SHALL pass a test with REFRESH_CYC=200, all inputs 0 and no changes -> three frames 0x01, 0x02, 0x04 every 200 cycles, with the queue refilled while transmission continues.
